cpu_wb_ctrl: RTL

- Writeback controller that drives the general-register write port (rd_wen/rd_idx/rd_dat) of the register file.
- Merges single-cycle ALU results with multi-cycle load responses from the LSU, and aligns and sign/zero-extends load data.
- Buffers load results that collide with ALU writes.
- Keeps a load scoreboard so decode can stall on registers whose load result is still pending.

---
 rtl/cpu_wb_pkg.sv | 22 ++
 rtl/cpu_wb_fifo.sv | 45 ++++
 rtl/cpu_wb_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_wb_pkg.sv
// Writeback shared definitions: core widths, load funct3 codes and
// the writeback source select encoding.
package cpu_wb_pkg;

    localparam int CPU_XLEN          = 32;
    localparam int CPU_GREGIDX_WIDTH = 5;
    localparam int CPU_GREG_COUNT    = 1 << CPU_GREGIDX_WIDTH;

    localparam logic [2:0] CPU_LD_LB  = 3'b000;
    localparam logic [2:0] CPU_LD_LH  = 3'b001;
    localparam logic [2:0] CPU_LD_LW  = 3'b010;
    localparam logic [2:0] CPU_LD_LBU = 3'b100;
    localparam logic [2:0] CPU_LD_LHU = 3'b101;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_BYP  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/cpu_wb_fifo.sv
// Small synchronous FIFO holding extended load results {idx, data}
// that could not be written back in the cycle they were accepted.
module cpu_wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Entry storage; contents are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/cpu_wb_ctrl.sv
// Writeback controller: merges ALU results and load responses onto the
// register-file write port and tracks registers with loads in flight.
module cpu_wb_ctrl
    import cpu_wb_pkg::*;
#(
    parameter int XLEN       = CPU_XLEN,
    parameter int IDX_W      = CPU_GREGIDX_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [IDX_W-1:0] alu_rd_idx,
    input  logic [XLEN-1:0]  alu_dat,
    input  logic             lsu_issue,
    input  logic [IDX_W-1:0] lsu_issue_rd,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [IDX_W-1:0] lsu_rd_idx,
    input  logic [2:0]       lsu_funct3,
    input  logic [1:0]       lsu_addr_lo,
    input  logic [XLEN-1:0]  lsu_rdata,
    input  logic             wb_hold,
    input  logic [IDX_W-1:0] rs1_idx,
    input  logic [IDX_W-1:0] rs2_idx,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_wen,
    output logic [IDX_W-1:0] rd_idx,
    output logic [XLEN-1:0]  rd_dat
);

    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int NREG = 1 << IDX_W;
    localparam int EW   = IDX_W + XLEN;

    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [XLEN-1:0]  ld_ext;
    logic             lsu_acc;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [EW-1:0]    fifo_head;
    logic [CW-1:0]    fifo_count;
    wb_src_e          src;
    logic [IDX_W-1:0] wr_idx;
    logic [XLEN-1:0]  wr_dat;
    logic             rd_ld_q;
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_nxt;

    assign ld_b = lsu_rdata[{lsu_addr_lo, 3'b000} +: 8];
    assign ld_h = lsu_rdata[{lsu_addr_lo[1], 4'b0000} +: 16];

    // Align and extend load data as it is accepted.
    always_comb begin
        ld_ext = lsu_rdata;
        case (lsu_funct3)
            CPU_LD_LB:  ld_ext = {{(XLEN-8){ld_b[7]}}, ld_b};
            CPU_LD_LH:  ld_ext = {{(XLEN-16){ld_h[15]}}, ld_h};
            CPU_LD_LBU: ld_ext = {{(XLEN-8){1'b0}}, ld_b};
            CPU_LD_LHU: ld_ext = {{(XLEN-16){1'b0}}, ld_h};
            default:    ld_ext = lsu_rdata;
        endcase
    end

    assign alu_ready  = !wb_hold;
    assign fifo_empty = (fifo_count == '0);
    assign lsu_ready  = (fifo_count < CW'(FIFO_DEPTH));
    assign lsu_acc    = lsu_valid && lsu_ready;

    // Pick this cycle's write source: ALU, then buffered loads, then bypass.
    always_comb begin
        src = SRC_NONE;
        if (!wb_hold) begin
            if (alu_valid)        src = SRC_ALU;
            else if (!fifo_empty) src = SRC_FIFO;
            else if (lsu_acc)     src = SRC_BYP;
        end
    end

    assign fifo_pop  = (src == SRC_FIFO);
    assign fifo_push = lsu_acc && (src != SRC_BYP);

    // Mux the selected result onto the write bus.
    always_comb begin
        wr_idx = '0;
        wr_dat = '0;
        unique case (1'b1)
            (src == SRC_ALU): begin
                wr_idx = alu_rd_idx;
                wr_dat = alu_dat;
            end
            (src == SRC_FIFO): begin
                wr_idx = fifo_head[EW-1:XLEN];
                wr_dat = fifo_head[XLEN-1:0];
            end
            (src == SRC_BYP): begin
                wr_idx = lsu_rd_idx;
                wr_dat = ld_ext;
            end
            default: ;
        endcase
    end

    cpu_wb_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat ({lsu_rd_idx, ld_ext}),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    // Register the write port; x0 writes retire silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_wen  <= 1'b0;
            rd_idx  <= '0;
            rd_dat  <= '0;
            rd_ld_q <= 1'b0;
        end else begin
            rd_wen  <= (src != SRC_NONE) && (wr_idx != '0);
            rd_ld_q <= (src == SRC_FIFO) || (src == SRC_BYP);
            if (src != SRC_NONE) begin
                rd_idx <= wr_idx;
                rd_dat <= wr_dat;
            end
        end
    end

    // Scoreboard update: clear on load writeback, set on issue (set wins).
    always_comb begin
        busy_nxt = busy_q;
        if (rd_wen && rd_ld_q) busy_nxt[rd_idx] = 1'b0;
        if (lsu_issue && (lsu_issue_rd != '0)) busy_nxt[lsu_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_nxt;
    end

    assign rs1_busy = busy_q[rs1_idx];
    assign rs2_busy = busy_q[rs2_idx];

endmodule
